// File: rtl/sram_stream_reader_pkg.sv
// Shared constants and types for the SRAM-to-stream reader.
// MAX_ADDR_WIDTH / SRAM_WIDTH_O mirror the bank constants used across the memory subsystem.
package sram_stream_reader_pkg;

    localparam int MAX_ADDR_WIDTH = 16;
    localparam int SRAM_WIDTH_O   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sram_stream_reader_if.sv
// Command, SRAM bank and output stream signals of the reader.
// The master modport is the reader; the slave modport is its environment.
interface sram_stream_reader_if
    import sram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = MAX_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_WIDTH_O,
    parameter int LEN_WIDTH  = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  len;
    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, base_addr, len, sram_data, m_ready,
        output sram_en, sram_we, sram_addr, m_valid, m_data, m_last, busy, done
    );

    modport slave (
        output start, base_addr, len, sram_data, m_ready,
        input  sram_en, sram_we, sram_addr, m_valid, m_data, m_last, busy, done
    );

endinterface

// File: rtl/sram_stream_reader_fifo2.sv
// Two-entry FIFO holding returned read words until the stream consumer takes them.
// Entries reset to zero so the head reads as zero after reset.
module fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);

    logic [1:0][WIDTH-1:0] mem;
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/sram_stream_reader.sv
// Streams len consecutive words from a synchronous SRAM bank, starting at base_addr,
// through a two-entry buffer with valid/ready back-pressure.
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = MAX_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_WIDTH_O,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_stream_reader_if.master bus
);

    state_t                state, state_nxt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  iss_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  in_flight;
    logic                  in_flight_last;
    logic [1:0]            fifo_cnt;
    logic [DATA_WIDTH:0]   head;
    logic [2:0]            occ;
    logic                  pop;
    logic                  issue;
    logic                  issue_last;
    logic                  busy_c;
    logic                  done_c;

    assign pop = bus.m_valid & bus.m_ready;
    // Buffered words plus the read in flight, net of this cycle's pop, must leave a free slot.
    assign occ = {1'b0, fifo_cnt} + {2'b0, in_flight} - {2'b0, pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_last = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = (bus.len == '0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                busy_c     = 1'b1;
                issue      = (occ < 3'd2);
                issue_last = issue && (iss_cnt == len_q - LEN_WIDTH'(1));
                if (issue_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy_c = 1'b1;
                if (pop && head[DATA_WIDTH]) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q          <= '0;
            iss_cnt        <= '0;
            addr_q         <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.start) begin
                len_q   <= bus.len;
                addr_q  <= bus.base_addr;
                iss_cnt <= '0;
            end else if (issue) begin
                addr_q  <= addr_q + ADDR_WIDTH'(1);
                iss_cnt <= iss_cnt + LEN_WIDTH'(1);
            end
            // The last flag travels with the read so it lands in the FIFO beside its data.
            in_flight      <= issue;
            in_flight_last <= issue_last;
        end
    end

    fifo2 #(.WIDTH(DATA_WIDTH + 1)) u_fifo2 (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight),
        .push_data ({in_flight_last, bus.sram_data}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_cnt)
    );

    assign bus.sram_en   = issue;
    assign bus.sram_we   = 1'b0;
    assign bus.sram_addr = addr_q;
    assign bus.m_valid   = (fifo_cnt != 2'd0);
    assign bus.m_data    = head[DATA_WIDTH-1:0];
    assign bus.m_last    = bus.m_valid & head[DATA_WIDTH];
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Randomized bench: a registered-read SRAM model feeds the reader; the expected stream is
// derived directly from base/len/memory contents and checked cycle by cycle.
module tb_sram_stream_reader;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus_if ();

    sram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    logic [DW-1:0] mem [16];

    // Registered-read bank: data valid the cycle after sram_en, noise otherwise.
    always @(posedge clk)
        bus_if.sram_data <= bus_if.sram_en ? mem[bus_if.sram_addr] : DW'($urandom);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_en"},    bus_if.sram_en, 0);
        chk({tag, "_we"},    bus_if.sram_we, 0);
        chk({tag, "_addr"},  bus_if.sram_addr, 0);
        chk({tag, "_valid"}, bus_if.m_valid, 0);
        chk({tag, "_last"},  bus_if.m_last, 0);
        chk({tag, "_data"},  bus_if.m_data, 0);
        chk({tag, "_busy"},  bus_if.busy, 0);
        chk({tag, "_done"},  bus_if.done, 0);
    endtask

    // Called at a point where the next posedge samples start. mode: 0 ready, 1 pattern 1,0,0, 2 random.
    task automatic xfer(input logic [AW-1:0] base, input int n, input int mode,
                        input int abort_after, input bit poke);
        logic [AW-1:0] exp_addr [$];
        logic [DW:0]   exp_word [$];
        logic [AW-1:0] a;
        logic [DW-1:0] held;
        int  iss = 0, popd = 0, hs_t = -1, t = 0;
        bit  stalled = 0, done_seen = 0, exp_done, exp_busy;

        for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
        for (int k = 0; k < n; k++) begin
            a = base + AW'(k);
            exp_addr.push_back(a);
            exp_word.push_back({(k == n - 1), mem[a]});
        end

        bus_if.start     = 1'b1;
        bus_if.base_addr = base;
        bus_if.len       = LW'(n);
        while (!done_seen && t < 300) begin
            @(negedge clk);
            t++;
            bus_if.start = 1'b0;
            if (poke && t == 2) begin
                bus_if.start     = 1'b1;
                bus_if.base_addr = base + AW'(7);
                bus_if.len       = LW'(3);
            end
            case (mode)
                0:       bus_if.m_ready = 1'b1;
                1:       bus_if.m_ready = (t % 3 == 1);
                default: bus_if.m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (t == 1) begin
                chk("first_en", bus_if.sram_en, (n != 0));
                if (n != 0) chk("first_addr", bus_if.sram_addr, base);
            end
            if (mode == 0 && n != 0 && (t == 2 || t == 3))
                chk("first_valid_t", bus_if.m_valid, (t == 3));
            if (bus_if.sram_en) begin
                chk("en_budget", (iss < n), 1);
                if (iss < n) chk("addr", bus_if.sram_addr, exp_addr[iss]);
                iss++;
            end
            if (stalled) begin
                chk("stall_valid", bus_if.m_valid, 1);
                chk("stall_data", bus_if.m_data, held);
            end
            if (bus_if.m_valid && bus_if.m_ready) begin
                chk("word_budget", (popd < n), 1);
                if (popd < n) chk("word", {bus_if.m_last, bus_if.m_data}, exp_word[popd]);
                popd++;
                if (popd == n) hs_t = t;
            end
            stalled = bus_if.m_valid && !bus_if.m_ready;
            held    = bus_if.m_data;
            chk("occupancy", ((iss - popd) <= 2), 1);
            exp_done = (n == 0) ? (t == 1) : (hs_t >= 0 && t == hs_t + 1);
            exp_busy = (n != 0) && (hs_t < 0 || t == hs_t);
            chk("done", bus_if.done, exp_done);
            chk("busy", bus_if.busy, exp_busy);
            chk("we", bus_if.sram_we, 0);
            if (abort_after > 0 && popd >= abort_after) return;
            if (bus_if.done) done_seen = 1;
        end
        chk("done_seen", done_seen, 1);
        chk("all_reads", iss, n);
        chk("all_words", popd, n);
        // A start presented during the done cycle must not launch a transfer.
        bus_if.start = 1'b1;
        bus_if.len   = LW'(3);
        @(negedge clk);
        bus_if.start = 1'b0;
        #1;
        chk("done_start_en", bus_if.sram_en, 0);
        chk("done_start_busy", bus_if.busy, 0);
        chk("done_start_done", bus_if.done, 0);
    endtask

    initial begin
        bus_if.start     = 1'b0;
        bus_if.base_addr = '0;
        bus_if.len       = '0;
        bus_if.m_ready   = 1'b0;
        #12;
        chk_reset_outs("rst");
        @(negedge clk);
        rst = 1'b1;

        xfer(AW'(10), 4, 0, 0, 0);
        xfer(AW'($urandom), 4, 1, 0, 0);
        xfer(AW'($urandom), 0, 0, 0, 0);
        xfer(AW'(14), 4, 0, 0, 0);
        xfer(AW'(3), 4, 0, 0, 1);

        // Abort mid-transfer, then restart immediately after reset release.
        xfer(AW'(5), 8, 0, 2, 0);
        #2 rst = 1'b0;
        #1 chk_reset_outs("abort");
        repeat (2) begin
            @(negedge clk);
            #1 chk("abort_no_done", bus_if.done, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        xfer(AW'(9), 2, 0, 0, 0);

        for (int r = 0; r < 20; r++)
            xfer(AW'($urandom), $urandom_range(0, 9), (r % 2 == 0) ? 2 : 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
